// File: rtl/tcni_rx_depacketizer_pkg.sv
// Shared types and header-field helpers for the TCNI receive path.
package Tcni;

  localparam int FLIT_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    SIZE,
    PAYLOAD,
    DONE,
    DROP
  } tcni_rx_state_t;

  function automatic logic [7:0] hdr_x(input logic [FLIT_W-1:0] flit);
    return flit[15:8];
  endfunction

  function automatic logic [7:0] hdr_y(input logic [FLIT_W-1:0] flit);
    return flit[7:0];
  endfunction

endpackage

// File: rtl/tcni_rx_packer.sv
// Packs 16-bit payload flits into 32-bit memory writes at base + 4*word_idx.
module tcni_rx_packer #(
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic              flit_valid,
  input  logic [15:0]       flit,
  input  logic              last,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data
);

  logic [ADDR_W-1:0] base_q;
  logic [15:0]       hi;
  logic              have_hi;
  logic [15:0]       word_idx;
  logic [ADDR_W-1:0] word_addr;

  assign word_addr = base_q + ADDR_W'({word_idx, 2'b00});

  // A lone last flit flushes with a zero low half.
  always_ff @(posedge clock) begin
    if (reset) begin
      base_q   <= '0;
      hi       <= '0;
      have_hi  <= 1'b0;
      word_idx <= '0;
      mem_wr   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
    end else begin
      mem_wr <= 1'b0;
      if (start) begin
        base_q   <= base;
        word_idx <= '0;
        have_hi  <= 1'b0;
      end else if (flit_valid) begin
        if (have_hi || last) begin
          mem_wr   <= 1'b1;
          mem_addr <= word_addr;
          mem_data <= have_hi ? {hi, flit} : {flit, 16'h0000};
          word_idx <= word_idx + 16'd1;
          have_hi  <= 1'b0;
        end else begin
          hi      <= flit;
          have_hi <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/tcni_rx_depacketizer.sv
// TCNI receive depacketizer: flits in, 32-bit scratch-memory writes and a packet irq out.
// Define TCNI_RX_ADDR_CHECK_EN to drop packets whose header does not match cfg_local_i.
module tcni_rx_depacketizer #(
  parameter int FLIT_W = 16,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              noc_rx_i,
  input  logic [FLIT_W-1:0] noc_data_i,
  output logic              noc_credit_o,
  output logic              mem_wr_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_data_o,
  input  logic [ADDR_W-1:0] cfg_base_i,
  input  logic [15:0]       cfg_max_w_i,
  input  logic [FLIT_W-1:0] cfg_local_i,
  output logic              irq_o,
  output logic [15:0]       recv_len_o,
  input  logic              ack_i,
  output logic [CNT_W-1:0]  drop_cnt_o
);

  import Tcni::*;

  tcni_rx_state_t state, state_nxt;

  logic        accept;
  logic [15:0] size;
  logic [16:0] need_w;
  logic        oversize;
  logic        size_zero;
  logic        hdr_ok;
  logic        hdr_match;
  logic        drop_pkt;
  logic [15:0] rem;
  logic        last_flit;
  logic        pk_start;
  logic        pk_flit;
  logic        ack_ok;
  logic        irq_set;

  assign accept    = noc_rx_i && noc_credit_o;
  assign size      = 16'(noc_data_i);
  assign need_w    = ({1'b0, size} + 17'd1) >> 1;
  assign oversize  = need_w > {1'b0, cfg_max_w_i};
  assign size_zero = (size == 16'd0);
  assign drop_pkt  = !hdr_ok || oversize;
  assign last_flit = (rem == 16'd1);
  assign ack_ok    = (state == DONE) && ack_i && irq_o;
  assign irq_set   = ((state == SIZE) && accept && !drop_pkt && size_zero) ||
                     ((state == DONE) && mem_wr_o);

`ifdef TCNI_RX_ADDR_CHECK_EN
  assign hdr_match = (hdr_x(noc_data_i) == hdr_x(cfg_local_i)) &&
                     (hdr_y(noc_data_i) == hdr_y(cfg_local_i));
`else
  logic unused_local;
  assign unused_local = ^cfg_local_i;
  assign hdr_match    = 1'b1;
`endif

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pk_start  = 1'b0;
    pk_flit   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = SIZE;
          pk_start  = 1'b1;
        end
      end
      SIZE: begin
        if (accept) begin
          if (drop_pkt)       state_nxt = size_zero ? IDLE : DROP;
          else if (size_zero) state_nxt = DONE;
          else                state_nxt = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (accept) begin
          pk_flit = 1'b1;
          if (last_flit) state_nxt = DONE;
        end
      end
      DONE: begin
        if (ack_ok) state_nxt = IDLE;
      end
      DROP: begin
        if (accept && last_flit) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Credit follows the next state so DONE holds off the router from its first cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      noc_credit_o <= 1'b0;
      irq_o        <= 1'b0;
      recv_len_o   <= '0;
      drop_cnt_o   <= '0;
      rem          <= '0;
      hdr_ok       <= 1'b0;
    end else begin
      noc_credit_o <= (state_nxt != DONE);
      if ((state == IDLE) && accept) hdr_ok <= hdr_match;
      if ((state == SIZE) && accept) begin
        rem <= size;
        if (drop_pkt) begin
          if (drop_cnt_o != {CNT_W{1'b1}}) drop_cnt_o <= drop_cnt_o + 1'b1;
        end else begin
          recv_len_o <= size;
        end
      end else if (((state == PAYLOAD) || (state == DROP)) && accept) begin
        rem <= rem - 16'd1;
      end
      if (ack_ok)       irq_o <= 1'b0;
      else if (irq_set) irq_o <= 1'b1;
    end
  end

  tcni_rx_packer #(.ADDR_W(ADDR_W)) u_packer (
    .clock      (clock),
    .reset      (reset),
    .start      (pk_start),
    .base       (cfg_base_i),
    .flit_valid (pk_flit),
    .flit       (16'(noc_data_i)),
    .last       (last_flit),
    .mem_wr     (mem_wr_o),
    .mem_addr   (mem_addr_o),
    .mem_data   (mem_data_o)
  );

endmodule

// File: tb/tb_tcni_rx_depacketizer.sv
// Scoreboard bench for tcni_rx_depacketizer: expected writes and irq lengths are queued per packet.
module tb_tcni_rx_depacketizer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        noc_rx_i = 1'b0;
  logic [15:0] noc_data_i = '0;
  logic        noc_credit_o;
  logic        mem_wr_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic [31:0] cfg_base_i = 32'h0000_0100;
  logic [15:0] cfg_max_w_i = 16'd16;
  logic [15:0] cfg_local_i = 16'h0101;
  logic        irq_o;
  logic [15:0] recv_len_o;
  logic        ack_i = 1'b0;
  logic [7:0]  drop_cnt_o;

  tcni_rx_depacketizer dut (
    .clock        (clock),
    .reset        (reset),
    .noc_rx_i     (noc_rx_i),
    .noc_data_i   (noc_data_i),
    .noc_credit_o (noc_credit_o),
    .mem_wr_o     (mem_wr_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .cfg_base_i   (cfg_base_i),
    .cfg_max_w_i  (cfg_max_w_i),
    .cfg_local_i  (cfg_local_i),
    .irq_o        (irq_o),
    .recv_len_o   (recv_len_o),
    .ack_i        (ack_i),
    .drop_cnt_o   (drop_cnt_o)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [15:0] exp_len_q[$];

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Writes and irq rises are compared against the queues as the DUT produces them.
  logic        irq_prev = 1'b0;
  logic        wr_prev = 1'b0;
  logic [15:0] len_exp;
  always @(negedge clock) begin
    if (mem_wr_o === 1'b1) begin
      if (exp_addr_q.size() == 0) checkOutput("wr_unexpected", 64'd1, 64'd0);
      else begin
        checkOutput("wr_addr", 64'(mem_addr_o), 64'(exp_addr_q.pop_front()));
        checkOutput("wr_data", 64'(mem_data_o), 64'(exp_data_q.pop_front()));
      end
    end
    if (irq_o === 1'b1 && !irq_prev) begin
      if (exp_len_q.size() == 0) checkOutput("irq_unexpected", 64'd1, 64'd0);
      else begin
        len_exp = exp_len_q.pop_front();
        checkOutput("recv_len", 64'(recv_len_o), 64'(len_exp));
        if (len_exp != 16'd0) checkOutput("irq_after_final_wr", 64'(wr_prev), 64'd1);
      end
    end
    irq_prev = (irq_o === 1'b1);
    wr_prev  = (mem_wr_o === 1'b1);
  end

  task automatic applyStimulus(input logic [15:0] f);
    int n = 0;
    @(negedge clock);
    noc_rx_i   = 1'b1;
    noc_data_i = f;
    while (!noc_credit_o && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) checkOutput("credit_timeout", 64'd0, 64'd1);
    @(posedge clock);
  endtask

  task automatic idleBus();
    @(negedge clock);
    noc_rx_i = 1'b0;
  endtask

  task automatic sendPacket(input logic [15:0] hdr, input logic [15:0] flits[$], input bit deliver);
    int s = flits.size();
    if (deliver) begin
      for (int i = 0; i < s; i += 2) begin
        exp_addr_q.push_back(cfg_base_i + 32'(4 * (i / 2)));
        exp_data_q.push_back({flits[i], (i + 1 < s) ? flits[i+1] : 16'h0000});
      end
      exp_len_q.push_back(16'(s));
    end
    applyStimulus(hdr);
    applyStimulus(16'(s));
    foreach (flits[i]) applyStimulus(flits[i]);
  endtask

  task automatic ackIrq();
    int n = 0;
    while (!irq_o && n < 200) begin
      @(negedge clock);
      n++;
    end
    checkOutput("irq_seen", 64'(irq_o), 64'd1);
    @(negedge clock);
    ack_i = 1'b1;
    @(negedge clock);
    ack_i = 1'b0;
    checkOutput("irq_cleared", 64'(irq_o), 64'd0);
    checkOutput("credit_after_ack", 64'(noc_credit_o), 64'd1);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_credit"}, 64'(noc_credit_o), 64'd0);
    checkOutput({tag, "_mem_wr"}, 64'(mem_wr_o), 64'd0);
    checkOutput({tag, "_mem_addr"}, 64'(mem_addr_o), 64'd0);
    checkOutput({tag, "_mem_data"}, 64'(mem_data_o), 64'd0);
    checkOutput({tag, "_irq"}, 64'(irq_o), 64'd0);
    checkOutput({tag, "_len"}, 64'(recv_len_o), 64'd0);
    checkOutput({tag, "_drop"}, 64'(drop_cnt_o), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] p[$];
    logic [15:0] q[$];
    int n;

    repeat (3) @(negedge clock);
    checkResetValues("reset");
    reset = 1'b0;

    // 1: four flits, two full words
    p = '{16'hA001, 16'hA002, 16'hA003, 16'hA004};
    sendPacket(16'h0101, p, 1'b1);
    idleBus();
    ackIrq();

    // 2: odd size, last word zero-padded
    p = '{16'h1111, 16'h2222, 16'h3333};
    sendPacket(16'h0101, p, 1'b1);
    idleBus();
    ackIrq();

    // 3: empty packet, irq one cycle after the size flit
    p = '{};
    sendPacket(16'h0101, p, 1'b1);
    @(negedge clock);
    noc_rx_i = 1'b0;
    checkOutput("s0_irq_timing", 64'(irq_o), 64'd1);
    ackIrq();

    // 4: oversize packet dropped, then a legal one delivered
    cfg_max_w_i = 16'd2;
    p = '{16'h0D01, 16'h0D02, 16'h0D03, 16'h0D04, 16'h0D05, 16'h0D06};
    sendPacket(16'h0101, p, 1'b0);
    idleBus();
    repeat (3) @(negedge clock);
    checkOutput("drop_cnt_oversize", 64'(drop_cnt_o), 64'd1);
    checkOutput("credit_after_drop", 64'(noc_credit_o), 64'd1);
    p = '{16'hB001, 16'hB002};
    sendPacket(16'h0101, p, 1'b1);
    idleBus();
    ackIrq();
    cfg_max_w_i = 16'd16;

    // 5: second packet offered while the first waits for ack
    p = '{16'hC001, 16'hC002};
    q = '{16'hD001, 16'hD002, 16'hD003};
    fork
      begin
        sendPacket(16'h0101, p, 1'b1);
        sendPacket(16'h0101, q, 1'b1);
        idleBus();
      end
      begin
        n = 0;
        while (!irq_o && n < 200) begin
          @(negedge clock);
          n++;
        end
        repeat (2) begin
          @(negedge clock);
          checkOutput("credit_held_done", 64'(noc_credit_o), 64'd0);
        end
        ackIrq();
      end
    join
    ackIrq();

    // 6: reset after two payload flits of a four-flit packet
    applyStimulus(16'h0101);
    applyStimulus(16'd4);
    applyStimulus(16'hE001);
    exp_addr_q.push_back(cfg_base_i);
    exp_data_q.push_back(32'hE001_E002);
    applyStimulus(16'hE002);
    @(negedge clock);
    reset    = 1'b1;
    noc_rx_i = 1'b0;
    repeat (2) @(negedge clock);
    checkResetValues("midreset");
    reset = 1'b0;
    p = '{16'hF001, 16'hF002};
    sendPacket(16'h0101, p, 1'b1);
    idleBus();
    ackIrq();

`ifdef TCNI_RX_ADDR_CHECK_EN
    // 7: header for another tile is dropped
    p = '{16'h7001, 16'h7002};
    sendPacket(16'h0102, p, 1'b0);
    idleBus();
    repeat (3) @(negedge clock);
    checkOutput("drop_cnt_addr", 64'(drop_cnt_o), 64'd1);
`endif

    repeat (4) @(negedge clock);
    checkOutput("wr_queue_empty", 64'(exp_addr_q.size()), 64'd0);
    checkOutput("irq_queue_empty", 64'(exp_len_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
